// File: rtl/axi_read_arbiter.sv
// Read-channel controller for the 2-master / 6-slave AXI bus: round-robin AR arbitration,
// address decode, AR forwarding, and a read-path lock held until the granted master's last beat.
module axi_read_arbiter #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [3:0]        ARLEN_M0,
    input  logic [3:0]        ARLEN_M1,
    input  logic [2:0]        ARSIZE_M0,
    input  logic [2:0]        ARSIZE_M1,
    input  logic [1:0]        ARBURST_M0,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M0,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M0,
    output logic              ARREADY_M1,
    output logic [ID_W+3:0]   ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [3:0]        ARLEN_S,
    output logic [2:0]        ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S0,
    output logic              ARVALID_S1,
    output logic              ARVALID_S2,
    output logic              ARVALID_S3,
    output logic              ARVALID_S4,
    output logic              ARVALID_S5,
    output logic              ARVALID_SD,
    input  logic              ARREADY_S0,
    input  logic              ARREADY_S1,
    input  logic              ARREADY_S2,
    input  logic              ARREADY_S3,
    input  logic              ARREADY_S4,
    input  logic              ARREADY_S5,
    input  logic              ARREADY_SD,
    input  logic              RVALID_M0,
    input  logic              RVALID_M1,
    input  logic              RREADY_M0,
    input  logic              RREADY_M1,
    input  logic              RLAST_M0,
    input  logic              RLAST_M1,
    output logic [3:0]        AR_sel
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    // Target codes 0..5 are S0..S5, 6 is the default slave.
    localparam logic [2:0] TgtSd = 3'd6;

    state_e     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [2:0] target_q, target_d;

    logic              win_m1;
    logic [ADDR_W-1:0] win_addr;
    logic [6:0]        arvalid_s;
    logic [6:0]        arready_s;
    logic              g_arvalid, g_rdone;

    function automatic logic [2:0] decode(input logic [ADDR_W-1:0] addr);
        logic [31:0] a;
        a = 32'(addr);
        if (a[31:14] == 18'h0)           return 3'd0;
        else if (a[31:16] == 16'h0001)   return 3'd1;
        else if (a[31:16] == 16'h0002)   return 3'd2;
        else if (a[31:10] == 22'h040000) return 3'd3;
        else if (a[31:10] == 22'h040040) return 3'd4;
        else if (a[31:21] == 11'h100)    return 3'd5;
        else                             return TgtSd;
    endfunction

    assign arready_s = {ARREADY_SD, ARREADY_S5, ARREADY_S4, ARREADY_S3,
                        ARREADY_S2, ARREADY_S1, ARREADY_S0};
    assign {ARVALID_SD, ARVALID_S5, ARVALID_S4, ARVALID_S3,
            ARVALID_S2, ARVALID_S1, ARVALID_S0} = arvalid_s;

    // On a tie the master that did not win last time gets the grant.
    assign win_m1    = (ARVALID_M0 && ARVALID_M1) ? !last_grant_q : ARVALID_M1;
    assign win_addr  = win_m1 ? ARADDR_M1 : ARADDR_M0;
    assign g_arvalid = grant_q ? ARVALID_M1 : ARVALID_M0;
    assign g_rdone   = grant_q ? (RVALID_M1 && RREADY_M1 && RLAST_M1)
                               : (RVALID_M0 && RREADY_M0 && RLAST_M0);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            target_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            target_q     <= target_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        target_d     = target_q;
        arvalid_s    = '0;
        ARREADY_M0   = 1'b0;
        ARREADY_M1   = 1'b0;
        AR_sel       = 4'b0000;
        ARID_S       = '0;
        ARADDR_S     = '0;
        ARLEN_S      = '0;
        ARSIZE_S     = '0;
        ARBURST_S    = '0;

        unique case (state_q)
            StIdle: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    grant_d      = win_m1;
                    last_grant_d = win_m1;
                    target_d     = decode(win_addr);
                    state_d      = StAddr;
                end
            end
            StAddr: begin
                arvalid_s[target_q] = g_arvalid;
                if (grant_q) ARREADY_M1 = arready_s[target_q];
                else         ARREADY_M0 = arready_s[target_q];
                if (g_arvalid && arready_s[target_q]) state_d = StData;
            end
            StData: begin
                if (g_rdone) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle) begin
            AR_sel    = {target_q + 3'd1, grant_q};
            ARID_S    = grant_q ? {4'b0010, ARID_M1} : {4'b0001, ARID_M0};
            ARADDR_S  = grant_q ? ARADDR_M1  : ARADDR_M0;
            ARLEN_S   = grant_q ? ARLEN_M1   : ARLEN_M0;
            ARSIZE_S  = grant_q ? ARSIZE_M1  : ARSIZE_M0;
            ARBURST_S = grant_q ? ARBURST_M1 : ARBURST_M0;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grant order, decode, AR_sel routing and lock release.
module tb_axi_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_S3, ARVALID_S4, ARVALID_S5;
    logic        ARVALID_SD;
    logic        ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_S3, ARREADY_S4, ARREADY_S5;
    logic        ARREADY_SD;
    logic        RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1;
    logic [3:0]  AR_sel;
    logic [6:0]  avs;

    int n_checks = 0;
    int n_fails  = 0;

    axi_read_arbiter #(.ID_W(4), .ADDR_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ARID_M0), .ARID_M1(ARID_M1),
        .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
        .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M0(ARSIZE_M0), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M0(ARBURST_M0), .ARBURST_M1(ARBURST_M1),
        .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
        .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1), .ARVALID_S2(ARVALID_S2),
        .ARVALID_S3(ARVALID_S3), .ARVALID_S4(ARVALID_S4), .ARVALID_S5(ARVALID_S5),
        .ARVALID_SD(ARVALID_SD),
        .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1), .ARREADY_S2(ARREADY_S2),
        .ARREADY_S3(ARREADY_S3), .ARREADY_S4(ARREADY_S4), .ARREADY_S5(ARREADY_S5),
        .ARREADY_SD(ARREADY_SD),
        .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
        .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
        .RLAST_M0(RLAST_M0), .RLAST_M1(RLAST_M1),
        .AR_sel(AR_sel)
    );

    always #5 ACLK = ~ACLK;

    assign avs = {ARVALID_SD, ARVALID_S5, ARVALID_S4, ARVALID_S3,
                  ARVALID_S2, ARVALID_S1, ARVALID_S0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_r0(input logic v, input logic r, input logic l);
        RVALID_M0 = v; RREADY_M0 = r; RLAST_M0 = l;
    endtask

    task automatic set_r1(input logic v, input logic r, input logic l);
        RVALID_M1 = v; RREADY_M1 = r; RLAST_M1 = l;
    endtask

    initial begin
        ARESETn = 1'b0;
        ARID_M0 = 4'd0; ARID_M1 = 4'd0; ARADDR_M0 = '0; ARADDR_M1 = '0;
        ARLEN_M0 = '0; ARLEN_M1 = '0; ARSIZE_M0 = 3'd2; ARSIZE_M1 = 3'd2;
        ARBURST_M0 = 2'b01; ARBURST_M1 = 2'b01; ARVALID_M0 = 0; ARVALID_M1 = 0;
        {ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_S3, ARREADY_S4, ARREADY_S5} = '0;
        ARREADY_SD = 0;
        set_r0(0, 0, 0); set_r1(0, 0, 0);

        // Reset state
        cyc(); cyc();
        chk("rst_sel", 32'(AR_sel), 32'h0);
        chk("rst_arvalid_s", 32'(avs), 32'h0);
        chk("rst_arready_m", 32'({ARREADY_M1, ARREADY_M0}), 32'h0);
        chk("rst_arid_s", 32'(ARID_S), 32'h0);

        // Single M0 read to S1
        ARESETn = 1; ARVALID_M0 = 1; ARADDR_M0 = 32'h0001_0040; ARID_M0 = 4'd3; ARLEN_M0 = 0;
        #1;
        chk("idle_sel", 32'(AR_sel), 32'h0);
        chk("idle_arready_m0", 32'(ARREADY_M0), 32'h0);
        cyc();
        chk("s1_sel", 32'(AR_sel), 32'h4);
        chk("s1_arvalid", 32'(avs), 32'h02);
        chk("s1_arid", 32'(ARID_S), 32'h13);
        chk("s1_araddr", ARADDR_S, 32'h0001_0040);
        chk("s1_arready_wait", 32'(ARREADY_M0), 32'h0);
        ARREADY_S1 = 1; #1;
        chk("s1_arready_m0", 32'(ARREADY_M0), 32'h1);
        cyc();
        ARVALID_M0 = 0; ARREADY_S1 = 0; #1;
        chk("s1_data_sel", 32'(AR_sel), 32'h4);
        chk("s1_data_arvalid", 32'(avs), 32'h0);
        chk("s1_data_arready", 32'(ARREADY_M0), 32'h0);
        set_r0(1, 1, 1);
        cyc();
        set_r0(0, 0, 0); #1;
        chk("s1_release", 32'(AR_sel), 32'h0);

        // Both masters from reset to S5: M0 first, then alternate
        ARESETn = 0; cyc();
        ARESETn = 1; ARVALID_M0 = 1; ARVALID_M1 = 1;
        ARADDR_M0 = 32'h2000_0000; ARADDR_M1 = 32'h2000_0000; ARID_M0 = 4'd5; ARID_M1 = 4'd9;
        ARREADY_S5 = 1;
        cyc();
        chk("rr_m0_sel", 32'(AR_sel), 32'hC);
        chk("rr_m0_arid", 32'(ARID_S), 32'h15);
        chk("rr_m0_arready_m1", 32'(ARREADY_M1), 32'h0);
        cyc();
        chk("rr_m0_data_sel", 32'(AR_sel), 32'hC);
        set_r0(1, 1, 1);
        cyc();
        set_r0(0, 0, 0); #1;
        chk("rr_bubble", 32'(AR_sel), 32'h0);
        cyc();
        chk("rr_m1_sel", 32'(AR_sel), 32'hD);
        chk("rr_m1_arid", 32'(ARID_S), 32'h29);
        chk("rr_m1_arready", 32'({ARREADY_M1, ARREADY_M0}), 32'h2);
        cyc();
        set_r1(1, 1, 1);
        cyc();
        set_r1(0, 0, 0);
        cyc();
        chk("rr_m0_again", 32'(AR_sel), 32'hC);
        cyc();
        ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S5 = 0;
        set_r0(1, 1, 1);
        cyc();
        set_r0(0, 0, 0); #1;
        chk("rr_done", 32'(AR_sel), 32'h0);

        // M1 to unmapped address goes to the default slave
        ARVALID_M1 = 1; ARADDR_M1 = 32'h3000_0000;
        cyc();
        chk("sd_sel", 32'(AR_sel), 32'hF);
        chk("sd_arvalid", 32'(avs), 32'h40);
        ARREADY_SD = 1;
        cyc();
        ARVALID_M1 = 0; ARREADY_SD = 0;
        set_r1(1, 1, 1);
        cyc();
        set_r1(0, 0, 0); #1;
        chk("sd_release", 32'(AR_sel), 32'h0);

        // M0 4-beat burst to S2, M1 requests mid-burst, RLAST stalled by RREADY
        ARVALID_M0 = 1; ARADDR_M0 = 32'h0002_0010; ARLEN_M0 = 4'd3;
        ARADDR_M1 = 32'h1000_0100;
        cyc();
        chk("s2_sel", 32'(AR_sel), 32'h6);
        chk("s2_arlen", 32'(ARLEN_S), 32'h3);
        ARREADY_S2 = 1;
        cyc();
        ARVALID_M0 = 0; ARREADY_S2 = 0; ARVALID_M1 = 1;
        set_r0(1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s2_beat_sel", 32'(AR_sel), 32'h6);
            chk("s2_beat_arready_m1", 32'(ARREADY_M1), 32'h0);
        end
        set_r0(1, 0, 1);
        set_r1(1, 1, 1);
        cyc();
        chk("s2_stall_sel", 32'(AR_sel), 32'h6);
        set_r1(0, 0, 0);
        set_r0(1, 1, 1);
        cyc();
        set_r0(0, 0, 0); #1;
        chk("s2_release", 32'(AR_sel), 32'h0);
        cyc();
        chk("s3_m1_sel", 32'(AR_sel), 32'h9);
        chk("s3_arvalid", 32'(avs), 32'h08);
        ARREADY_S3 = 1;
        cyc();
        ARVALID_M1 = 0; ARREADY_S3 = 0;
        set_r1(1, 1, 1);
        cyc();
        set_r1(0, 0, 0);

        // Reset during DATA, then tie goes to M0 again
        ARVALID_M0 = 1; ARADDR_M0 = 32'h1001_0020; ARLEN_M0 = 4'd1;
        cyc();
        chk("s4_sel", 32'(AR_sel), 32'hA);
        ARREADY_S4 = 1;
        cyc();
        ARREADY_S4 = 0; ARVALID_M1 = 1; ARADDR_M1 = 32'h0000_0000;
        ARESETn = 0;
        cyc();
        chk("abort_sel", 32'(AR_sel), 32'h0);
        chk("abort_arvalid", 32'(avs), 32'h0);
        chk("abort_arready", 32'({ARREADY_M1, ARREADY_M0}), 32'h0);
        ARESETn = 1;
        cyc();
        chk("abort_regrant_m0", 32'(AR_sel), 32'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Read-channel controller for the 2-master / 6-slave AXI bus.
- Arbitrates M0 and M1 read-address requests round-robin and decodes ARADDR to a slave or the default slave.
- Forwards the granted AR channel to that slave, then holds the read path locked until the burst's last beat is accepted.
- Drives AR_sel, which steers the read-data mux: RDATA/RRESP/RLAST/RVALID/RREADY routing between slaves and masters.

Parameters:
- ID_W, 4, master-side ARID width.
- ADDR_W, 32, address width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- ARID_M0 / ARID_M1  in  ID_W  master read IDs
- ARADDR_M0 / ARADDR_M1  in  ADDR_W  master read addresses
- ARLEN_M0 / ARLEN_M1  in  4  burst length minus 1
- ARSIZE_M0 / ARSIZE_M1  in  3  beat size
- ARBURST_M0 / ARBURST_M1  in  2  burst type
- ARVALID_M0 / ARVALID_M1  in  1  master address valid
- ARREADY_M0 / ARREADY_M1  out  1  address accepted
- ARID_S  out  ID_W+4  {master tag, ARID}, broadcast to all slaves
- ARADDR_S  out  ADDR_W  broadcast address
- ARLEN_S  out  4  broadcast burst length
- ARSIZE_S  out  3  broadcast beat size
- ARBURST_S  out  2  broadcast burst type
- ARVALID_S0..ARVALID_S5, ARVALID_SD  out  1  per-slave valid (SD = default slave)
- ARREADY_S0..ARREADY_S5, ARREADY_SD  in  1  per-slave ready
- RVALID_M0 / RVALID_M1  in  1  read-data valid as seen by each master (observed only)
- RREADY_M0 / RREADY_M1  in  1  read-data ready from each master (observed only)
- RLAST_M0 / RLAST_M1  in  1  last-beat flag as seen by each master (observed only)
- AR_sel  out  4  route code for the read-data mux

Behaviour:
- Reset (ARESETn=0 at ACLK edge):
  - state=IDLE, AR_sel=4'b0000, all ARVALID_S*=0, ARREADY_M*=0.
  - last_grant=M1, so M0 wins the first tie.
  - Reset mid-burst aborts the lock unconditionally.
- Address decode:
  - S0 0x0000_0000–0x0000_3FFF; S1 0x0001_0000–0x0001_FFFF; S2 0x0002_0000–0x0002_FFFF.
  - S3 0x1000_0000–0x1000_03FF; S4 0x1001_0000–0x1001_03FF; S5 0x2000_0000–0x201F_FFFF.
  - Any other address → SD.
- AR_sel encoding:
  - AR_sel[3:1] = slave index+1 (S0=1 … S5=6, SD=7); AR_sel[0] = granted master (0=M0, 1=M1).
  - 4'b0000 means idle (no route).
- ARID_S = {4'b0001, ARID_M0} when M0 is granted, {4'b0010, ARID_M1} when M1 is granted. All broadcast AR fields are 0 when no master is granted.
- IDLE:
  - All ARREADY_M*=0, all ARVALID_S*=0.
  - If either ARVALID_M* is high, register the grant: a single requester wins; if both request, the master other than last_grant wins.
  - Decode the winner's ARADDR, register the target and last_grant, go to ADDR.
  - Latency: ARVALID_M high in cycle N → ARVALID_Sx high in cycle N+1.
- ADDR:
  - AR_sel is driven. The granted master's AR fields are routed combinationally to the broadcast outputs.
  - ARVALID of the decoded target = granted ARVALID_M; every other ARVALID_S* = 0.
  - Granted ARREADY_M = target ARREADY; the non-granted master sees ARREADY=0.
  - On target ARVALID&ARREADY → DATA. Otherwise hold with no timeout.
- DATA:
  - AR_sel held; all ARVALID_S*=0; all ARREADY_M*=0.
  - Exit to IDLE on the cycle RVALID_Mg & RREADY_Mg & RLAST_Mg are all high, where g is the granted master.
  - The other master's R signals are ignored.
- Back-to-back: one IDLE bubble cycle between a burst's final beat and the next grant.
- Grant and target change only in IDLE. ARVALID changes by either master during ADDR/DATA never alter AR_sel.
- Only one outstanding read in the whole interconnect; no reordering.

Test Plan:
- Reset, then M0 ARVALID, ARADDR=0x0001_0040, ARID=3, ARLEN=0 → next cycle AR_sel=4'b0100, ARVALID_S1=1, ARID_S=8'h13. S1 ARREADY=1 → ARREADY_M0=1; single beat with RLAST handshake → AR_sel=0 next cycle.
- M0 and M1 both valid from reset, both to 0x2000_0000 → M0 granted first (AR_sel=4'b1100). After RLAST, M1 granted (AR_sel=4'b1101, ARID_S[7:4]=4'b0010). Alternation continues while both keep requesting.
- M1 ARADDR=0x3000_0000 → AR_sel=4'b1111, ARVALID_SD=1, all ARVALID_S0..S5=0.
- M0 burst ARLEN=3 to S2: first three beats leave AR_sel=4'b0110. RLAST beat with RREADY_M0=0 holds the lock; lock released only the cycle after RREADY_M0=1.
- M1 raises ARVALID while M0 is in DATA → ARREADY_M1 stays 0 and AR_sel unchanged until M0's last beat.
- ARESETn=0 during DATA → next cycle AR_sel=0, ARVALID_S*=0. With both masters requesting after release, M0 is granted.
